// File: rtl/rf_wb_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package rf_wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned MAX_REQ    = 4;

  typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;
  typedef logic [REG_ADDR_W-1:0]      reg_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the first asserted request at or after the pointer wins.
module rr_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  req_idx_t           i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic        w_found;
  int unsigned w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = (32'(i_ptr) + i) % NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter with busy scoreboard and hazard queries.
// Define RF_WB_BYPASS_EN to add write-port forwarding outputs.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]       req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic                                 rsv_valid,
  input  logic [REG_ADDR_W-1:0]                rsv_addr,
  input  logic                                 flush,
  output logic                                 rf_wr,
  output logic [REG_ADDR_W-1:0]                rf_a3,
  output logic [DATA_W-1:0]                    rf_wd,
  input  logic [REG_ADDR_W-1:0]                q_a1,
  input  logic [REG_ADDR_W-1:0]                q_a2,
  output logic                                 q_busy1,
  output logic                                 q_busy2,
`ifdef RF_WB_BYPASS_EN
  output logic                                 byp_hit1,
  output logic                                 byp_hit2,
  output logic [DATA_W-1:0]                    byp_data1,
  output logic [DATA_W-1:0]                    byp_data2,
`endif
  output logic                                 rsv_err
);

  logic [NUM_REQ-1:0]  w_req;
  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_gnt_any;
  req_idx_t            w_idx;
  reg_addr_t           w_addr;
  logic [DATA_W-1:0]   w_data;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic                w_err;

  req_idx_t            r_ptr;
  logic                r_wr;
  reg_addr_t           r_a3;
  logic [DATA_W-1:0]   r_wd;
  logic [NUM_REGS-1:0] r_busy;
  logic                r_err;

  // Nothing is granted during reset or flush.
  assign w_req = (rst || flush) ? '0 : req_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  assign req_ready = w_gnt;
  assign w_gnt_any = |w_gnt;

  always_comb begin
    w_idx  = '0;
    w_addr = '0;
    w_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_idx  = req_idx_t'(i);
        w_addr = req_addr[i];
        w_data = req_data[i];
      end
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (rsv_valid && rsv_addr != '0) w_set[rsv_addr] = 1'b1;
    if (w_gnt_any) w_clr[w_addr] = 1'b1;
    w_err = rsv_valid && !flush && (rsv_addr != '0) && r_busy[rsv_addr] && !w_clr[rsv_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_wr   <= 1'b0;
      r_a3   <= '0;
      r_wd   <= '0;
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wr <= w_gnt_any && (w_addr != '0);
      if (w_gnt_any) begin
        r_a3  <= w_addr;
        r_wd  <= w_data;
        r_ptr <= (w_idx == req_idx_t'(NUM_REQ - 1)) ? '0 : w_idx + req_idx_t'(1);
      end
      // Set after clear so a same-cycle reservation wins.
      if (flush) r_busy <= '0;
      else       r_busy <= (r_busy & ~w_clr) | w_set;
      if (w_err) r_err <= 1'b1;
    end
  end

  assign rf_wr   = r_wr;
  assign rf_a3   = r_a3;
  assign rf_wd   = r_wd;
  assign rsv_err = r_err;
  assign q_busy1 = (q_a1 != '0) && r_busy[q_a1];
  assign q_busy2 = (q_a2 != '0) && r_busy[q_a2];

`ifdef RF_WB_BYPASS_EN
  assign byp_hit1  = r_wr && (r_a3 == q_a1);
  assign byp_hit2  = r_wr && (r_a3 == q_a2);
  assign byp_data1 = r_wd;
  assign byp_data2 = r_wd;
`endif

endmodule
